// File: rtl/flow_pkg.sv
// rtl/flow_pkg.sv - shared mode constants and flat-bus channel slice helper
package flow_pkg;

    localparam int MODE_DIRECT = 0;
    localparam int MODE_RR     = 1;

    // Upper bound on NUM_CH*DATA_W that ch_slice can handle.
    localparam int MAX_BUS = 4096;

    function automatic logic [MAX_BUS-1:0] ch_slice(
        input logic [MAX_BUS-1:0] bus,
        input int                 k,
        input int                 w
    );
        return bus >> (k * w);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search with its own rotating pointer
module rr_arbiter #(
    parameter int NUM_CH = 32,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_valid
);

    int idx;

    // Scan starting at ptr, wrapping modulo NUM_CH; the first requester wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!gnt_valid && req[idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SEL_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/flow_mux_arb.sv
// rtl/flow_mux_arb.sv - N-channel selector feeding a one-beat registered valid/ready stage
module flow_mux_arb
    import flow_pkg::*;
#(
    parameter int NUM_CH = 32,
    parameter int DATA_W = 20,
    parameter int SEL_W  = $clog2(NUM_CH),
    parameter int MODE   = MODE_DIRECT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    logic [SEL_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               load_en;
    logic               xfer;
    logic [MAX_BUS-1:0] bus_pad;
    logic [DATA_W-1:0]  data_sel;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] rr_ptr;
            rr_arbiter #(
                .NUM_CH(NUM_CH),
                .SEL_W (SEL_W)
            ) u_arb (
                .clk      (clk),
                .rst_n    (rst_n),
                .req      (in_valid),
                .adv      (xfer),
                .ptr      (rr_ptr),
                .gnt_idx  (gnt_idx),
                .gnt_valid(gnt_valid)
            );
        end else begin : g_direct
            // Out-of-range sel matches no channel, so it never grants.
            always_comb begin
                gnt_idx   = sel;
                gnt_valid = 1'b0;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (sel == SEL_W'(k) && in_valid[k]) gnt_valid = 1'b1;
                end
            end
        end
    endgenerate

    assign load_en  = !out_valid || out_ready;
    assign xfer     = gnt_valid && load_en && rst_n;
    assign bus_pad  = MAX_BUS'(in_data);
    assign data_sel = DATA_W'(ch_slice(bus_pad, int'(gnt_idx), DATA_W));

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= data_sel;
            out_ch    <= gnt_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flow_mux_arb.sv
// tb/tb_flow_mux_arb.sv - directed checks of DIRECT (32 and 5 channel) and RR instances
module tb_flow_mux_arb;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: DIRECT, 32 channels
    logic [32*20-1:0] in_data_a;
    logic [31:0]      in_valid_a, in_ready_a;
    logic [4:0]       sel_a, out_ch_a;
    logic [19:0]      out_data_a;
    logic             out_valid_a, out_ready_a;

    // Instance B: RR, 32 channels
    logic [32*20-1:0] in_data_b;
    logic [31:0]      in_valid_b, in_ready_b;
    logic [4:0]       sel_b, out_ch_b;
    logic [19:0]      out_data_b;
    logic             out_valid_b, out_ready_b;

    // Instance C: DIRECT, 5 channels
    logic [5*20-1:0]  in_data_c;
    logic [4:0]       in_valid_c, in_ready_c;
    logic [2:0]       sel_c, out_ch_c;
    logic [19:0]      out_data_c;
    logic             out_valid_c, out_ready_c;

    flow_mux_arb #(.NUM_CH(32), .DATA_W(20), .MODE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_a), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .sel(sel_a), .out_data(out_data_a), .out_ch(out_ch_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a)
    );

    flow_mux_arb #(.NUM_CH(32), .DATA_W(20), .MODE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .sel(sel_b), .out_data(out_data_b), .out_ch(out_ch_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    flow_mux_arb #(.NUM_CH(5), .DATA_W(20), .MODE(0)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(in_data_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .sel(sel_c), .out_data(out_data_c), .out_ch(out_ch_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 32; k++) begin
            in_data_a[k*20 +: 20] = 20'(k);
            in_data_b[k*20 +: 20] = 20'(k);
        end
        for (int k = 0; k < 5; k++) in_data_c[k*20 +: 20] = 20'(k);
        in_valid_a = '1; in_valid_b = '1; in_valid_c = '1;
        sel_a = 5'd0; sel_b = 5'd0; sel_c = 3'd0;
        out_ready_a = 1'b1; out_ready_b = 1'b1; out_ready_c = 1'b1;
        tick;
        checks++;
        if (out_valid_a !== 1'b0 || out_data_a !== 20'd0 || out_ch_a !== 5'd0) begin
            errors++;
            $display("FAIL reset_a: valid=%0b data=%0d ch=%0d, required 0 0 0", out_valid_a, out_data_a, out_ch_a);
        end
        checks++;
        if (out_valid_b !== 1'b0 || out_valid_c !== 1'b0) begin
            errors++;
            $display("FAIL reset_bc: valid_b=%0b valid_c=%0b, required 0 0", out_valid_b, out_valid_c);
        end
        checks++;
        if (in_ready_a !== 32'd0 || in_ready_b !== 32'd0 || in_ready_c !== 5'd0) begin
            errors++;
            $display("FAIL reset_ready: a=%h b=%h c=%h, required all 0", in_ready_a, in_ready_b, in_ready_c);
        end
        in_valid_b = '0; in_valid_c = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_direct_seq;
        int seq [5] = '{0, 1, 2, 4, 31};
        for (int i = 0; i < 5; i++) begin
            sel_a = 5'(seq[i]);
            tick;
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== 20'(seq[i]) || out_ch_a !== 5'(seq[i])) begin
                errors++;
                $display("FAIL direct_seq[%0d]: valid=%0b data=%0d ch=%0d, required 1 %0d %0d",
                         i, out_valid_a, out_data_a, out_ch_a, seq[i], seq[i]);
            end
        end
    endtask

    task automatic test_direct_stall;
        in_valid_a = 32'h1 << 5;
        sel_a = 5'd5;
        tick;
        out_ready_a = 1'b0;
        in_data_a[5*20 +: 20] = 20'h55;
        #1;
        checks++;
        if (in_ready_a !== 32'd0) begin
            errors++;
            $display("FAIL stall_ready: in_ready=%h, required 0", in_ready_a);
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            checks++;
            if (out_valid_a !== 1'b1 || out_data_a !== 20'd5 || out_ch_a !== 5'd5 || in_ready_a !== 32'd0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%0b data=%0d ch=%0d ready=%h, required 1 5 5 0",
                         i, out_valid_a, out_data_a, out_ch_a, in_ready_a);
            end
        end
        out_ready_a = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== (32'h1 << 5)) begin
            errors++;
            $display("FAIL release_ready: in_ready=%h, required 00000020", in_ready_a);
        end
        tick;
        checks++;
        if (out_valid_a !== 1'b1 || out_data_a !== 20'h55 || out_ch_a !== 5'd5) begin
            errors++;
            $display("FAIL release_beat: valid=%0b data=%h ch=%0d, required 1 55 5", out_valid_a, out_data_a, out_ch_a);
        end
    endtask

    task automatic test_rr_all;
        in_valid_b = '1;
        #1;
        for (int i = 0; i < 34; i++) begin
            checks++;
            if (in_ready_b !== (32'h1 << (i % 32))) begin
                errors++;
                $display("FAIL rr_all_ready[%0d]: in_ready=%h, required bit %0d only", i, in_ready_b, i % 32);
            end
            tick;
            checks++;
            if (out_valid_b !== 1'b1 || out_ch_b !== 5'(i % 32) || out_data_b !== 20'(i % 32)) begin
                errors++;
                $display("FAIL rr_all_beat[%0d]: valid=%0b ch=%0d data=%0d, required 1 %0d %0d",
                         i, out_valid_b, out_ch_b, out_data_b, i % 32, i % 32);
            end
        end
    endtask

    task automatic test_rr_sparse;
        int exp_ch [4] = '{3, 30, 3, 30};
        in_valid_b = (32'h1 << 3) | (32'h1 << 30);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (in_ready_b !== (32'h1 << exp_ch[i])) begin
                errors++;
                $display("FAIL rr_sparse_ready[%0d]: in_ready=%h, required bit %0d only", i, in_ready_b, exp_ch[i]);
            end
            tick;
            checks++;
            if (out_ch_b !== 5'(exp_ch[i]) || out_data_b !== 20'(exp_ch[i])) begin
                errors++;
                $display("FAIL rr_sparse_beat[%0d]: ch=%0d data=%0d, required %0d", i, out_ch_b, out_data_b, exp_ch[i]);
            end
        end
    endtask

    task automatic test_sel_out_of_range;
        in_valid_c = '1;
        sel_c = 3'd3;
        tick;
        checks++;
        if (out_valid_c !== 1'b1 || out_ch_c !== 3'd3 || out_data_c !== 20'd3) begin
            errors++;
            $display("FAIL small_load: valid=%0b ch=%0d data=%0d, required 1 3 3", out_valid_c, out_ch_c, out_data_c);
        end
        sel_c = 3'd7;
        #1;
        checks++;
        if (in_ready_c !== 5'd0) begin
            errors++;
            $display("FAIL sel7_ready: in_ready=%h, required 0", in_ready_c);
        end
        tick;
        checks++;
        if (out_valid_c !== 1'b0 || out_ch_c !== 3'd3 || out_data_c !== 20'd3) begin
            errors++;
            $display("FAIL sel7_drain: valid=%0b ch=%0d data=%0d, required 0 3 3", out_valid_c, out_ch_c, out_data_c);
        end
    endtask

    task automatic test_mid_reset;
        in_valid_b = '1;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready_b !== 32'd0) begin
            errors++;
            $display("FAIL midrst_ready: in_ready=%h, required 0", in_ready_b);
        end
        tick;
        checks++;
        if (out_valid_b !== 1'b0 || out_data_b !== 20'd0 || out_ch_b !== 5'd0) begin
            errors++;
            $display("FAIL midrst_out: valid=%0b data=%0d ch=%0d, required 0 0 0", out_valid_b, out_data_b, out_ch_b);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready_b !== 32'h1) begin
            errors++;
            $display("FAIL midrst_restart_ready: in_ready=%h, required 00000001", in_ready_b);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            checks++;
            if (out_valid_b !== 1'b1 || out_ch_b !== 5'(i)) begin
                errors++;
                $display("FAIL midrst_restart[%0d]: valid=%0b ch=%0d, required 1 %0d", i, out_valid_b, out_ch_b, i);
            end
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_direct_seq;
        test_direct_stall;
        test_rr_all;
        test_rr_sparse;
        test_sel_out_of_range;
        test_mid_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
